// File: rtl/pixel_stream_reader_pkg.sv
// Shared definitions for the frame-buffer stream reader:
// FSM state encoding and the packed pixel width helper.
package pixel_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_t;

  function automatic int pix_width(
    input int iw,
    input int ch
  );
    return iw * ch;
  endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry skid buffer carrying data+last, head presented combinationally.
// Ports: push/push_data/push_last in, pop in, head_* out, occ (0..2) out.
module stream_skid_buffer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_last,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_last,
  output logic         head_valid,
  output logic [1:0]   occ
);

  logic [W-1:0] d0, d1;
  logic         l0, l1;
  logic [1:0]   cnt;
  logic         pop_ok, push_ok;

  assign pop_ok  = pop && (cnt != 2'd0);
  assign push_ok = push && ((cnt != 2'd2) || pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 2'd0;
      d0  <= '0;
      d1  <= '0;
      l0  <= 1'b0;
      l1  <= 1'b0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10: begin
          if (cnt == 2'd0) begin
            d0 <= push_data;
            l0 <= push_last;
          end else begin
            d1 <= push_data;
            l1 <= push_last;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          d0  <= d1;
          l0  <= l1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; new entry lands behind the survivor.
          if (cnt == 2'd1) begin
            d0 <= push_data;
            l0 <= push_last;
          end else begin
            d0 <= d1;
            l0 <= l1;
            d1 <= push_data;
            l1 <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_data  = d0;
  assign head_last  = l0;
  assign head_valid = (cnt != 2'd0);
  assign occ        = cnt;

endmodule

// File: rtl/pixel_stream_reader.sv
// Walks a sync-read pixel RAM and streams pixels over valid/ready.
// Ports: start/busy/done control, mem_* RAM read, output_* stream;
// stall_count exists only when STREAM_STATS_EN is defined.
module pixel_stream_reader
  import pixel_stream_reader_pkg::*;
#(
  parameter int I_WIDTH      = 8,
  parameter int CHANNELS     = 3,
  parameter int TOTAL_PIXELS = 2048,
  parameter int ADDR_WIDTH   = 11
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   mem_rd_en,
  output logic [ADDR_WIDTH-1:0]                  mem_addr,
  input  logic [pix_width(I_WIDTH,CHANNELS)-1:0] mem_rd_data,
  output logic [pix_width(I_WIDTH,CHANNELS)-1:0] output_data,
  output logic                                   output_valid,
  input  logic                                   output_ready,
  output logic                                   output_last
`ifdef STREAM_STATS_EN
  ,
  output logic [31:0]                            stall_count
`endif
);

  localparam int PW = pix_width(I_WIDTH, CHANNELS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    ADDR_WIDTH'(TOTAL_PIXELS - 1);

  rd_state_t             state, state_nx;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  inflight, inflight_last;
  logic                  issue_last, pop, head_last;
  logic [1:0]            occ;

  assign pop        = output_valid && output_ready;
  assign issue_last = (rd_addr == LAST_ADDR);
  assign mem_addr   = rd_addr;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);

  always_comb begin
    state_nx  = state;
    mem_rd_en = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_RUN;
      end
      ST_RUN: begin
        // occ + inflight - pop < 2, kept unsigned
        mem_rd_en = ({1'b0, occ} + {2'b00, inflight})
                  < (3'd2 + {2'b00, pop});
        if (mem_rd_en && issue_last) state_nx = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (pop && output_last) state_nx = ST_DONE;
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      rd_addr       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state         <= state_nx;
      inflight      <= mem_rd_en;
      inflight_last <= mem_rd_en && issue_last;
      if (state == ST_IDLE && start) rd_addr <= '0;
      else if (mem_rd_en)            rd_addr <= rd_addr + 1'b1;
    end
  end

  // The final pixel is tagged at issue time and rides the buffer.
  stream_skid_buffer #(
    .W (PW)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .push       (inflight),
    .push_data  (mem_rd_data),
    .push_last  (inflight_last),
    .pop        (pop),
    .head_data  (output_data),
    .head_last  (head_last),
    .head_valid (output_valid),
    .occ        (occ)
  );

  assign output_last = output_valid && head_last;

`ifdef STREAM_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || (state == ST_IDLE && start)) begin
      stall_count <= '0;
    end else if (output_valid && !output_ready
                 && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_stream_reader.sv
// Self-checking bench for pixel_stream_reader (2048-pixel and
// 1-pixel instances); STREAM_STATS_EN enables stall_count checks.
module tb_pixel_stream_reader;

  localparam int IW = 8;
  localparam int CH = 3;
  localparam int N  = 2048;
  localparam int AW = 11;
  localparam int PW = IW * CH;

  typedef struct packed {
    logic [PW-1:0] d;
    logic          l;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, start, busy, done, mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [PW-1:0] mem_rd_data, output_data;
  logic          output_valid, output_ready, output_last;

  logic          start1, busy1, done1, rd_en1;
  logic [0:0]    addr1;
  logic [PW-1:0] rd_data1, data1;
  logic          valid1, ready1, last1;
`ifdef STREAM_STATS_EN
  logic [31:0]   stall_count, stall_count1;
`endif

  logic [PW-1:0] ram [N];
  exp_t          q[$];
  int            tests = 0;
  int            fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_addr];
    if (rd_en1)    rd_data1    <= 24'hABCDEF;
  end

  pixel_stream_reader #(
    .I_WIDTH(IW), .CHANNELS(CH),
    .TOTAL_PIXELS(N), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data),
    .output_data(output_data), .output_valid(output_valid),
    .output_ready(output_ready), .output_last(output_last)
`ifdef STREAM_STATS_EN
    , .stall_count(stall_count)
`endif
  );

  pixel_stream_reader #(
    .I_WIDTH(IW), .CHANNELS(CH),
    .TOTAL_PIXELS(1), .ADDR_WIDTH(1)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .busy(busy1), .done(done1),
    .mem_rd_en(rd_en1), .mem_addr(addr1),
    .mem_rd_data(rd_data1),
    .output_data(data1), .output_valid(valid1),
    .output_ready(ready1), .output_last(last1)
`ifdef STREAM_STATS_EN
    , .stall_count(stall_count1)
`endif
  );

  task automatic load_frame();
    q.delete();
    for (int i = 0; i < N; i++)
      q.push_back('{d: ram[i], l: (i == N - 1)});
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; start1 = 1'b1;
    output_ready = 1'b0; ready1 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if ({busy, done, mem_rd_en, output_valid, output_last} !== 5'b0
        || mem_addr !== '0 || output_data !== '0) begin
      fails++;
      $display("FAIL reset_outputs ctl=%b addr=%h data=%h exp=0",
               {busy, done, mem_rd_en, output_valid, output_last},
               mem_addr, output_data);
    end
    tests++;
    if ({busy1, done1, rd_en1, valid1, last1} !== 5'b0) begin
      fails++;
      $display("FAIL reset_outputs1 ctl=%b exp=0",
               {busy1, done1, rd_en1, valid1, last1});
    end
`ifdef STREAM_STATS_EN
    tests++;
    if (stall_count !== 32'd0) begin
      fails++;
      $display("FAIL reset_stall got=%0d exp=0", stall_count);
    end
`endif
    @(negedge clk); reset = 1'b0; start = 1'b0; start1 = 1'b0;
    @(negedge clk); #1;
    tests++;
    if (busy !== 1'b0 || busy1 !== 1'b0) begin
      fails++;
      $display("FAIL start_with_reset busy=%b/%b exp=0/0", busy, busy1);
    end
  endtask

  task automatic test_full_rate();
    int got = 0;
    int n = 0;
    exp_t e;
    output_ready = 1'b1;
    @(negedge clk); start = 1'b1; load_frame();
    @(negedge clk); start = 1'b0; #1;
    tests++;
    if (busy !== 1'b1 || mem_rd_en !== 1'b1 || mem_addr !== '0) begin
      fails++;
      $display("FAIL latency_read busy=%b rd_en=%b addr=%0d exp=1/1/0",
               busy, mem_rd_en, mem_addr);
    end
    @(negedge clk); #1;
    tests++;
    if (output_valid !== 1'b0) begin
      fails++;
      $display("FAIL latency_early_valid got=%b exp=0", output_valid);
    end
    @(negedge clk); #1;
    while (got < N) begin
      if (n > N + 20) begin
        tests++; fails++;
        $display("FAIL full_rate_timeout got=%0d exp=%0d", got, N);
        break;
      end
      tests++;
      if (output_valid !== 1'b1) begin
        fails++;
        $display("FAIL full_rate_bubble idx=%0d valid=%b exp=1",
                 got, output_valid);
      end else begin
        e = q.pop_front();
        if (output_data !== e.d || output_last !== e.l) begin
          fails++;
          $display("FAIL full_rate_pixel idx=%0d got=%h/%b exp=%h/%b",
                   got, output_data, output_last, e.d, e.l);
        end
        got++;
      end
      @(negedge clk); #1; n++;
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b1 || output_valid !== 1'b0) begin
      fails++;
      $display("FAIL full_rate_done done=%b busy=%b valid=%b exp=1/1/0",
               done, busy, output_valid);
    end
    @(negedge clk); #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL full_rate_idle done=%b busy=%b exp=0/0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0]    pat = 4'b1001;
    int            cyc = 0;
    int            got = 0;
    int            stalls = 0;
    int            occ_m = 0;
    int            inf_m = 0;
    int            pop_m;
    logic [PW-1:0] held_d = '0;
    logic          held_l = 1'b0;
    logic          stalled = 1'b0;
    exp_t          e;
    @(negedge clk); start = 1'b1; load_frame();
    while (got < N) begin
      @(negedge clk);
      start = 1'b0;
      output_ready = pat[cyc % 4];
      #1;
      cyc++;
      if (cyc > 4 * N + 100) begin
        tests++; fails++;
        $display("FAIL bp_timeout got=%0d exp=%0d", got, N);
        break;
      end
      pop_m = (output_valid && output_ready) ? 1 : 0;
      if (stalled) begin
        tests++;
        if (output_valid !== 1'b1 || output_data !== held_d
            || output_last !== held_l) begin
          fails++;
          $display("FAIL bp_hold got=%b/%h/%b exp=1/%h/%b",
                   output_valid, output_data, output_last,
                   held_d, held_l);
        end
      end
      tests++;
      if (output_valid !== (occ_m != 0)) begin
        fails++;
        $display("FAIL bp_valid got=%b exp=%b", output_valid, occ_m != 0);
      end
      if (mem_rd_en) begin
        tests++;
        if (occ_m + inf_m - pop_m >= 2) begin
          fails++;
          $display("FAIL bp_issue occ+inf-pop=%0d exp<2",
                   occ_m + inf_m - pop_m);
        end
      end
      if (pop_m == 1) begin
        e = q.pop_front();
        tests++;
        if (output_data !== e.d || output_last !== e.l) begin
          fails++;
          $display("FAIL bp_pixel idx=%0d got=%h/%b exp=%h/%b",
                   got, output_data, output_last, e.d, e.l);
        end
        got++;
      end
      if (output_valid && !output_ready) stalls++;
      stalled = output_valid && !output_ready;
      held_d  = output_data;
      held_l  = output_last;
      occ_m   = occ_m + inf_m - pop_m;
      inf_m   = mem_rd_en ? 1 : 0;
    end
    @(negedge clk); output_ready = 1'b1; #1;
    tests++;
    if (done !== 1'b1 || output_valid !== 1'b0 || q.size() != 0) begin
      fails++;
      $display("FAIL bp_done done=%b valid=%b left=%0d exp=1/0/0",
               done, output_valid, q.size());
    end
`ifdef STREAM_STATS_EN
    tests++;
    if (stall_count !== 32'(stalls)) begin
      fails++;
      $display("FAIL bp_stall_count got=%0d exp=%0d", stall_count, stalls);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_ready_low();
    int   reads = 0;
    exp_t e;
    q.delete();
    q.push_back('{d: ram[0], l: 1'b0});
    q.push_back('{d: ram[1], l: 1'b0});
    output_ready = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
`ifdef STREAM_STATS_EN
    tests++;
    if (stall_count !== 32'd0) begin
      fails++;
      $display("FAIL start_clears_stall got=%0d exp=0", stall_count);
    end
`endif
    for (int i = 0; i < 10; i++) begin
      if (mem_rd_en) begin
        tests++;
        if (mem_addr !== AW'(reads)) begin
          fails++;
          $display("FAIL rl_addr got=%0d exp=%0d", mem_addr, reads);
        end
        reads++;
      end
      @(negedge clk); #1;
    end
    tests++;
    if (reads != 2) begin
      fails++;
      $display("FAIL rl_reads got=%0d exp=2", reads);
    end
    output_ready = 1'b1; #1;
    for (int i = 0; i < 2; i++) begin
      e = q.pop_front();
      tests++;
      if (output_valid !== 1'b1 || output_data !== e.d) begin
        fails++;
        $display("FAIL rl_pixel idx=%0d got=%b/%h exp=1/%h",
                 i, output_valid, output_data, e.d);
      end
      @(negedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    int   got = 0;
    int   n = 0;
    exp_t e;
    output_ready = 1'b1;
    @(negedge clk); start = 1'b1; load_frame();
    @(negedge clk); start = 1'b0;
    while (got < 700 && n < 800) begin
      #1;
      if (output_valid) begin
        e = q.pop_front();
        tests++;
        if (output_data !== e.d) begin
          fails++;
          $display("FAIL mid_pixel idx=%0d got=%h exp=%h",
                   got, output_data, e.d);
        end
        got++;
      end
      @(negedge clk); n++;
    end
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    tests++;
    if ({busy, done, mem_rd_en, output_valid, output_last} !== 5'b0
        || mem_addr !== '0 || output_data !== '0) begin
      fails++;
      $display("FAIL mid_reset ctl=%b addr=%h data=%h exp=0",
               {busy, done, mem_rd_en, output_valid, output_last},
               mem_addr, output_data);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      tests++;
      if (output_valid !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL mid_spurious valid=%b busy=%b exp=0/0",
                 output_valid, busy);
      end
    end
    load_frame();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    tests++;
    if (mem_rd_en !== 1'b1 || mem_addr !== '0) begin
      fails++;
      $display("FAIL mid_replay_addr rd_en=%b addr=%0d exp=1/0",
               mem_rd_en, mem_addr);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      e = q.pop_front();
      tests++;
      if (output_valid !== 1'b1 || output_data !== e.d) begin
        fails++;
        $display("FAIL mid_replay idx=%0d got=%b/%h exp=1/%h",
                 i, output_valid, output_data, e.d);
      end
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_start_busy();
    int   got = 0;
    int   n = 0;
    exp_t e;
    output_ready = 1'b1;
    @(negedge clk); start = 1'b1; load_frame();
    while (got < N && n < N + 50) begin
      @(negedge clk);
      start = (n == 5 || n == 100 || n == 1000);
      #1; n++;
      if (output_valid) begin
        e = q.pop_front();
        tests++;
        if (output_data !== e.d || output_last !== e.l) begin
          fails++;
          $display("FAIL sb_pixel idx=%0d got=%h/%b exp=%h/%b",
                   got, output_data, output_last, e.d, e.l);
        end
        got++;
      end
    end
    start = 1'b0;
    tests++;
    if (got != N) begin
      fails++;
      $display("FAIL sb_count got=%0d exp=%0d", got, N);
    end
    @(negedge clk); #1;
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL sb_done got=%b exp=1", done);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      tests++;
      if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
        fails++;
        $display("FAIL sb_requeue busy=%b rd_en=%b exp=0/0",
                 busy, mem_rd_en);
      end
    end
  endtask

  task automatic test_single();
    exp_t e;
    q.delete();
    q.push_back('{d: 24'hABCDEF, l: 1'b1});
    ready1 = 1'b1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0; #1;
    tests++;
    if (busy1 !== 1'b1 || rd_en1 !== 1'b1 || addr1 !== 1'b0) begin
      fails++;
      $display("FAIL single_read busy=%b rd_en=%b addr=%b exp=1/1/0",
               busy1, rd_en1, addr1);
    end
    @(negedge clk); #1;
    tests++;
    if (rd_en1 !== 1'b0 || valid1 !== 1'b0) begin
      fails++;
      $display("FAIL single_flush rd_en=%b valid=%b exp=0/0",
               rd_en1, valid1);
    end
    @(negedge clk); #1;
    e = q.pop_front();
    tests++;
    if (valid1 !== 1'b1 || data1 !== e.d || last1 !== e.l) begin
      fails++;
      $display("FAIL single_pixel got=%b/%h/%b exp=1/%h/%b",
               valid1, data1, last1, e.d, e.l);
    end
    @(negedge clk); #1;
    tests++;
    if (done1 !== 1'b1 || valid1 !== 1'b0) begin
      fails++;
      $display("FAIL single_done done=%b valid=%b exp=1/0", done1, valid1);
    end
    @(negedge clk); #1;
    tests++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      fails++;
      $display("FAIL single_idle busy=%b done=%b exp=0/0", busy1, done1);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++)
      ram[i] = PW'(i * 24'h010203);
    test_reset();
    test_full_rate();
    test_backpressure();
    test_ready_low();
    test_reset_mid();
    test_start_busy();
    test_single();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_stream_reader.md
Name: pixel_stream_reader

Overview:
- Frame-buffer-to-stream source: walks a synchronous-read pixel RAM from address 0 to TOTAL_PIXELS-1.
- Emits one packed pixel of CHANNELS x I_WIDTH bits per valid/ready handshake into the layer pipeline (feeds relu_layer and later layers).
- Handles consumer backpressure with a 2-entry skid buffer, so sustained throughput is 1 pixel/clk.

Parameters:
- I_WIDTH, 8, bits per channel
- CHANNELS, 3, channels per pixel
- TOTAL_PIXELS, 2048, pixels per frame (>=1)
- ADDR_WIDTH, 11, RAM address width; must satisfy 2^ADDR_WIDTH >= TOTAL_PIXELS

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin one frame; ignored while busy
- busy  out  1  high from the cycle after an accepted start until the done pulse
- done  out  1  one-cycle pulse after the final pixel handshake
- mem_rd_en  out  1  RAM read strobe
- mem_addr  out  ADDR_WIDTH  RAM read address
- mem_rd_data  in  I_WIDTH*CHANNELS  RAM data, valid exactly 1 clk after mem_rd_en
- output_data  out  I_WIDTH*CHANNELS  pixel to layer
- output_valid  out  1  output_data valid
- output_ready  in  1  consumer accepts
- output_last  out  1  high with the final pixel of the frame
- stall_count  out  32  present only with STREAM_STATS_EN

Behaviour:
- One clock (clk). Reset is synchronous, active-high.
- Reset values: state IDLE; busy, done, mem_rd_en, output_valid, output_last = 0; mem_addr, output_data = 0; buffer emptied; in-flight read discarded.
- Reset mid-frame aborts immediately. The RAM result returning in the following cycle is dropped.
- FSM states:
  - IDLE: start=1 -> RUN; rd_addr=0, out_idx=0.
  - RUN: issues reads. After issuing address TOTAL_PIXELS-1 -> FLUSH.
  - FLUSH: no reads. When the final handshake occurs -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- busy=1 in RUN, FLUSH and DONE.
- Read issue rule:
  - mem_rd_en = (state==RUN) && (occ + inflight - pop) < 2.
  - occ = buffer entries (0..2); inflight = read issued last cycle; pop = output_valid && output_ready.
  - mem_addr = rd_addr; rd_addr increments on each issue.
  - The buffer can never overflow.
- Returned data is pushed into the buffer the cycle after its read. output_data/output_valid present the buffer head.
- Latency: start sampled at edge E0 -> mem_rd_en high after E0 -> output_valid high after E2.
- With output_ready held at 1, one pixel transfers per clk with no bubbles.
- Stream rules:
  - While output_valid && !output_ready, output_data and output_last hold stable.
  - output_valid never drops without a handshake.
- output_last = output_valid && (out_idx == TOTAL_PIXELS-1). out_idx increments on pop.
- done asserts in the cycle after the last-pixel handshake. The reader returns to IDLE the cycle after that; the earliest next start is accepted in IDLE.
- start in the same cycle as reset: reset wins.
- start during busy: ignored, no queuing.
- TOTAL_PIXELS=1:
  - Single read issued in RUN, then state goes straight to FLUSH.
  - output_last is asserted on the first valid pixel.
- output_ready may be asserted while output_valid=0; no effect.

Optional Feature:
- Macro: STREAM_STATS_EN.
- Defined: stall_count port exists.
  - Increments each cycle with output_valid && !output_ready, saturating at 2^32-1.
  - Cleared by reset and by an accepted start.
- Undefined: port, counter and logic are absent; all other behaviour is identical.

Decomposition:
- Shared definitions package (alongside existing common definitions): FSM state encoding (IDLE=0, RUN=1, FLUSH=2, DONE=3) and the pixel-width expression I_WIDTH*CHANNELS.
- One sub-module: stream_skid_buffer (2-entry, data+last, push/pop, occ output), reusable by later layers.
- Address/index counters and the FSM stay in the top module.

Test Plan:
- Full-rate frame: RAM[i]=i*0x010203 mod 2^24, TOTAL_PIXELS=2048, output_ready=1.
  - 2048 pixels out in order, on consecutive cycles after the first.
  - output_last only on pixel 2047.
  - done pulse the cycle after; busy low the following cycle.
- Backpressure: output_ready toggles 1,0,0,1 repeatedly.
  - No loss or duplication; output_data stable while stalled.
  - mem_rd_en never issued with occ+inflight-pop>=2.
  - With STREAM_STATS_EN, stall_count=2*1024 minus prologue stalls, checked exactly against the bench model.
- Ready held low for 10 cycles after start:
  - Exactly 2 reads issued (addr 0,1), then mem_rd_en stays 0.
  - Pixel 0 is presented when ready rises.
- Reset mid-frame at pixel 700:
  - All outputs 0 next cycle; no spurious output_valid.
  - A new start replays from address 0.
- start pulsed while busy is ignored; TOTAL_PIXELS=1 build emits one pixel with output_last=1 and done one cycle after its handshake.
